// File: rtl/graphics_datapath_pkg.sv
// graphics_datapath_pkg: colour constants, widths and base-colour lookup for the tile game datapath
package graphics_datapath_pkg;
    localparam int IDX_W   = 2;
    localparam int VGA_X_W = 8;
    localparam int VGA_Y_W = 7;
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GRN   = 3'b010;
    localparam logic [2:0] BLU   = 3'b001;
    localparam logic [2:0] YEL   = 3'b110;
    localparam logic [2:0] FLASH = 3'b111;
    function automatic logic [2:0] base_colour(input logic [IDX_W-1:0] t);
        return t == 2'd0 ? RED : t == 2'd1 ? GRN : t == 2'd2 ? BLU : YEL;
    endfunction
endpackage

// File: rtl/graphics_datapath_tile_lfsr.sv
// tile_lfsr: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing only when enabled
module tile_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       en,
    output logic [7:0] q
);
    always_ff @(posedge clock) begin
        if (!resetn) q <= SEED;
        else if (en) q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
endmodule

// File: rtl/graphics_datapath.sv
// graphics_datapath: tile select, colour, random tile pick and pixel sweep for the 2x2 tile game
module graphics_datapath
    import graphics_datapath_pkg::*;
#(
    parameter int TILE_W = 32,
    parameter int TILE_H = 32,
    parameter int X0 = 16,
    parameter int Y0 = 8,
    parameter int GAP = 8,
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                ld_tile,
    input  logic                ld_flash,
    input  logic                write_en,
    input  logic                counter_en,
    input  logic                random_en,
    input  logic [2:0]          tile_num,
    output logic [VGA_X_W-1:0]  x,
    output logic [VGA_Y_W-1:0]  y,
    output logic [2:0]          colour,
    output logic                plot,
    output logic                draw_done,
    output logic [IDX_W-1:0]    rand_tile
);
    localparam int CX_W = $clog2(TILE_W);
    localparam int CY_W = $clog2(TILE_H);
    localparam logic [VGA_X_W-1:0] BX0 = VGA_X_W'(X0);
    localparam logic [VGA_X_W-1:0] BX1 = VGA_X_W'(X0 + TILE_W + GAP);
    localparam logic [VGA_Y_W-1:0] BY0 = VGA_Y_W'(Y0);
    localparam logic [VGA_Y_W-1:0] BY1 = VGA_Y_W'(Y0 + TILE_H + GAP);
    logic [7:0]       lfsr;
    logic             game_mode;
    logic [IDX_W-1:0] tile_idx;
    logic [IDX_W-1:0] next_idx;
    logic [CX_W-1:0]  cx;
    logic [CY_W-1:0]  cy;
    logic             last_x;
    logic             last_y;
    logic             unused_bits;
    tile_lfsr #(.SEED(SEED)) u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .en     (random_en),
        .q      (lfsr)
    );
    always_comb begin
        next_idx = game_mode ? lfsr[1:0] : tile_num[1:0];
        last_x = cx == CX_W'(TILE_W - 1);
        last_y = cy == CY_W'(TILE_H - 1);
    end
    assign x = (tile_idx[0] ? BX1 : BX0) + VGA_X_W'(cx);
    assign y = (tile_idx[1] ? BY1 : BY0) + VGA_Y_W'(cy);
    assign plot = write_en & counter_en;
    assign rand_tile = lfsr[1:0];
    assign unused_bits = ^{tile_num[2], lfsr[7:2]};
    always_ff @(posedge clock) begin
        if (!resetn) begin
            tile_idx  <= '0;
            colour    <= BLACK;
            cx        <= '0;
            cy        <= '0;
            game_mode <= 1'b0;
            draw_done <= 1'b0;
        end else begin
            draw_done <= 1'b0;
            if (random_en) game_mode <= 1'b1;
            // A tile load restarts the sweep and suppresses any completion on the same edge
            if (ld_tile) begin
                tile_idx <= next_idx;
                cx       <= '0;
                cy       <= '0;
            end else if (counter_en) begin
                cx <= last_x ? '0 : cx + 1'b1;
                if (last_x) cy <= last_y ? '0 : cy + 1'b1;
                draw_done <= last_x & last_y;
            end
            if (ld_flash) colour <= FLASH;
            else if (ld_tile) colour <= base_colour(next_idx);
        end
    end
endmodule

// File: tb/tb_graphics_datapath.sv
// tb_graphics_datapath: directed scenarios plus random stimulus against a pixel-index model
module tb_graphics_datapath;
    localparam int W = 32;
    localparam int H = 32;
    logic clock = 0, resetn = 0;
    logic ld_tile = 0, ld_flash = 0, write_en = 0, counter_en = 0, random_en = 0;
    logic [2:0] tile_num = 0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic plot, draw_done;
    logic [1:0] rand_tile;
    int checks = 0, errors = 0, done_cnt = 0;
    bit chk_on = 0;
    int m_idx, m_col, m_pix, m_nidx;
    bit m_gm, m_done;
    logic [7:0] m_lfsr;

    graphics_datapath dut (
        .clock(clock), .resetn(resetn), .ld_tile(ld_tile), .ld_flash(ld_flash),
        .write_en(write_en), .counter_en(counter_en), .random_en(random_en),
        .tile_num(tile_num), .x(x), .y(y), .colour(colour), .plot(plot),
        .draw_done(draw_done), .rand_tile(rand_tile)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    function automatic int colour_of(input int t);
        int tbl[4] = '{4, 2, 1, 6};
        return tbl[t];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        if (!resetn) begin
            m_idx = 0; m_col = 0; m_pix = 0; m_gm = 0; m_lfsr = 8'hA5; m_done = 0;
        end else begin
            m_nidx = m_gm ? int'(m_lfsr) % 4 : int'(tile_num) % 4;
            m_done = 0;
            if (ld_tile) begin
                m_idx = m_nidx;
                m_pix = 0;
            end else if (counter_en) begin
                m_done = m_pix == W * H - 1;
                m_pix = (m_pix + 1) % (W * H);
            end
            if (ld_flash) m_col = 7;
            else if (ld_tile) m_col = colour_of(m_idx);
            if (random_en) begin
                m_lfsr = lfsr_next(m_lfsr);
                m_gm = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("x", int'(x), (m_idx % 2 == 1 ? 56 : 16) + m_pix % W);
            chk("y", int'(y), (m_idx / 2 == 1 ? 48 : 8) + m_pix / W);
            chk("colour", int'(colour), m_col);
            chk("plot", int'(plot), int'(write_en & counter_en));
            chk("draw_done", int'(draw_done), int'(m_done));
            chk("rand_tile", int'(rand_tile), int'(m_lfsr[1:0]));
        end
        if (draw_done) done_cnt++;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        cyc(2);
        resetn = 1;
        chk_on = 1;
        chk("reset_x", int'(x), 16);
        chk("reset_y", int'(y), 8);
        chk("reset_colour", int'(colour), 0);
        chk("reset_done", int'(draw_done), 0);
        tile_num = 2; ld_tile = 1; cyc(); ld_tile = 0;
        chk("t1_colour", int'(colour), 1);
        chk("t1_x", int'(x), 16);
        chk("t1_y", int'(y), 48);
        counter_en = 1; write_en = 1; done_cnt = 0;
        cyc(W * H - 1);
        chk("t2_last_x", int'(x), 47);
        chk("t2_last_y", int'(y), 79);
        chk("t2_plot", int'(plot), 1);
        cyc();
        chk("t2_done", int'(draw_done), 1);
        chk("t2_wrap_x", int'(x), 16);
        chk("t2_wrap_y", int'(y), 48);
        counter_en = 0; write_en = 0; cyc();
        chk("t2_done_low", int'(draw_done), 0);
        chk("t2_done_count", done_cnt, 1);
        tile_num = 3; ld_tile = 1; cyc(); ld_tile = 0;
        counter_en = 1; cyc(5);
        chk("t4_cx5", int'(x), 61);
        ld_tile = 1; cyc(); ld_tile = 0; counter_en = 0;
        chk("t4_x", int'(x), 56);
        chk("t4_y", int'(y), 48);
        chk("t4_done", int'(draw_done), 0);
        tile_num = 1; ld_tile = 1; ld_flash = 1; cyc(); ld_tile = 0; ld_flash = 0;
        chk("t6_x", int'(x), 56);
        chk("t6_y", int'(y), 8);
        chk("t6_colour", int'(colour), 7);
        tile_num = 0; ld_tile = 1; cyc(); ld_tile = 0;
        counter_en = 1; cyc(W * 4 + 10);
        chk("t5_mid_x", int'(x), 26);
        chk("t5_mid_y", int'(y), 12);
        resetn = 0; cyc(); resetn = 1; counter_en = 0;
        chk("t5_colour", int'(colour), 0);
        chk("t5_x", int'(x), 16);
        chk("t5_y", int'(y), 8);
        chk("t5_done", int'(draw_done), 0);
        random_en = 1; cyc(3); random_en = 0;
        chk("t3_rand", int'(rand_tile), 2);
        tile_num = 1; ld_tile = 1; cyc(); ld_tile = 0;
        chk("t3_x", int'(x), 16);
        chk("t3_y", int'(y), 48);
        ld_flash = 1; cyc(); ld_flash = 0;
        chk("t3_flash", int'(colour), 7);
        chk("t3_flash_y", int'(y), 48);
        ld_tile = 1; cyc(); ld_tile = 0;
        chk("t3_restore", int'(colour), 1);
        chk("t3_same_y", int'(y), 48);
        for (int i = 0; i < 6000; i++) begin
            if (i == 3000) begin
                resetn = 0; cyc(); resetn = 1;
            end
            ld_tile    = $urandom_range(0, 199) == 0;
            ld_flash   = $urandom_range(0, 99) == 0;
            counter_en = $urandom_range(0, 9) < 7;
            write_en   = $urandom_range(0, 1);
            random_en  = $urandom_range(0, 19) == 0;
            tile_num   = 3'($urandom);
            cyc();
        end
        ld_tile = 0; ld_flash = 0; counter_en = 0; write_en = 0; random_en = 0;
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
